job_kernel_adapter: RTL

- Kernel-side endpoint of the job scheduler's per-kernel dispatch/completion interface, one instance per kernel slot.
- Accepts a HOST_DWIDTH job descriptor on the start/ready handshake and drives a single action engine through start/done/abort.
- Returns a RETURN_WIDTH completion word (PASID plus 32-bit return code) on the complete_ready/complete_accept handshake.
- Adds a per-job watchdog timeout and status counters.

---
 rtl/job_kernel_adapter_if.sv | 23 ++
 rtl/job_kernel_adapter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/job_kernel_adapter_if.sv
// Scheduler-facing dispatch/completion bus of one kernel slot.
// master = scheduler side, slave = kernel adapter side.
interface job_kernel_adapter_if #(
    parameter int HOST_DWIDTH  = 1024,
    parameter int RETURN_WIDTH = 41
);
    logic                    kernel_start;
    logic [HOST_DWIDTH-1:0]  kernel_data;
    logic                    kernel_ready;
    logic                    complete_ready;
    logic                    complete_accept;
    logic [RETURN_WIDTH-1:0] complete_data;

    modport master (
        output kernel_start, kernel_data, complete_accept,
        input  kernel_ready, complete_ready, complete_data
    );

    modport slave (
        input  kernel_start, kernel_data, complete_accept,
        output kernel_ready, complete_ready, complete_data
    );
endinterface

// File: rtl/job_kernel_adapter.sv
// Kernel-side job endpoint: takes a descriptor, runs one action engine with a
// per-job watchdog, and hands back {pasid, return code} as a completion word.
module job_kernel_adapter #(
    parameter int          HOST_DWIDTH  = 1024,
    parameter int          PASID_WIDTH  = 9,
    parameter int          RETURN_WIDTH = 41,
    parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD0001
) (
    input  logic                    clk,
    input  logic                    rst,
    job_kernel_adapter_if.slave     sched,
    output logic                    act_start,
    output logic [HOST_DWIDTH-65:0] act_param,
    output logic [PASID_WIDTH-1:0]  act_pasid,
    input  logic                    act_done,
    input  logic [31:0]             act_rc,
    output logic                    act_abort,
    output logic                    stray_done,
    output logic [31:0]             jobs_done,
    output logic [15:0]             timeouts
);

    if (RETURN_WIDTH != PASID_WIDTH + 32) begin : g_width_check
        $error("RETURN_WIDTH must equal PASID_WIDTH+32");
    end

    typedef enum logic [1:0] {IDLE, RUN, CMPL} state_t;

    state_t      state, state_n;
    logic [31:0] tmo;
    logic [31:0] wdog;
    logic        kernel_ready_n, complete_ready_n, act_start_n, act_abort_n;
    logic        take, fin_done, fin_tmo, accept, stray_n;
    logic        unused_desc_bits;

    assign unused_desc_bits = ^sched.kernel_data[31:PASID_WIDTH];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state plus next values of the registered control outputs
    always_comb begin
        state_n          = state;
        kernel_ready_n   = 1'b0;
        complete_ready_n = 1'b0;
        act_start_n      = 1'b0;
        act_abort_n      = 1'b0;
        take             = 1'b0;
        fin_done         = 1'b0;
        fin_tmo          = 1'b0;
        accept           = 1'b0;
        stray_n          = 1'b0;
        case (state)
            IDLE: begin
                stray_n = act_done;
                // kernel_ready is still low in the first cycle out of reset
                if (sched.kernel_ready && sched.kernel_start) begin
                    take        = 1'b1;
                    act_start_n = 1'b1;
                    state_n     = RUN;
                end else begin
                    kernel_ready_n = 1'b1;
                end
            end
            RUN: begin
                if (act_done) begin
                    fin_done         = 1'b1;
                    complete_ready_n = 1'b1;
                    state_n          = CMPL;
                end else if (tmo != 32'd0 && wdog == tmo) begin
                    fin_tmo          = 1'b1;
                    act_abort_n      = 1'b1;
                    complete_ready_n = 1'b1;
                    state_n          = CMPL;
                end
            end
            CMPL: begin
                stray_n = act_done;
                if (sched.complete_ready && sched.complete_accept) begin
                    accept         = 1'b1;
                    kernel_ready_n = 1'b1;
                    state_n        = IDLE;
                end else begin
                    complete_ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sched.kernel_ready   <= 1'b0;
            sched.complete_ready <= 1'b0;
            sched.complete_data  <= '0;
            act_start            <= 1'b0;
            act_abort            <= 1'b0;
            act_param            <= '0;
            act_pasid            <= '0;
            tmo                  <= '0;
            wdog                 <= '0;
            stray_done           <= 1'b0;
            jobs_done            <= '0;
            timeouts             <= '0;
        end else begin
            sched.kernel_ready   <= kernel_ready_n;
            sched.complete_ready <= complete_ready_n;
            act_start            <= act_start_n;
            act_abort            <= act_abort_n;
            stray_done           <= stray_done | stray_n;
            if (take) begin
                act_param <= sched.kernel_data[HOST_DWIDTH-1:64];
                act_pasid <= sched.kernel_data[PASID_WIDTH-1:0];
                tmo       <= sched.kernel_data[63:32];
                wdog      <= '0;
            end else if (state == RUN) begin
                wdog <= wdog + 32'd1;
            end
            if (fin_done) sched.complete_data <= {act_pasid, act_rc};
            if (fin_tmo) begin
                sched.complete_data <= {act_pasid, TIMEOUT_CODE};
                timeouts            <= sat_inc16(timeouts);
            end
            if (accept) jobs_done <= jobs_done + 32'd1;
        end
    end

endmodule
